instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Parametrised successor to the single-register program counter: a PC, a read port into
//  instruction RAM and a prefetch queue. Handshakes instructions plus their PC to decode/ALU.
//  Supports backpressure, branch redirect with flush, and halt.
//  Sits between Ram's fetch port and the RegisterBank/ALU decode split.
// PARAMETERS
//  ADDR_W    16  width of PC and fetch address
//  INSTR_W   32  instruction width
//  Q_DEPTH   4   prefetch queue entries; power of two, >=2
//  PC_STEP   1   PC increment per fetch (word-addressed RAM)
//  RESET_PC  0   first fetch address after reset
// PORTS
//  clk            in   1        rising-edge clock
//  rst            in   1        asynchronous, active-high reset
//  fetch_en       out  1        read strobe to instruction RAM
//  fetch_address  out  ADDR_W   RAM read address; valid when fetch_en=1
//  fetch_out      in   INSTR_W  RAM data; valid exactly 1 cycle after fetch_en
//  instr_valid    out  1        queue head is valid
//  instr_ready    in   1        consumer accepts head this cycle
//  instruction    out  INSTR_W  head instruction
//  instr_pc       out  ADDR_W   address of head instruction
//  branch_en      in   1        redirect request, single-cycle pulse
//  branch_target  in   ADDR_W   redirect address
//  halt           in   1        level; while high, no new fetch is issued
//  PC             out  ADDR_W   next address to be fetched
// BEHAVIOUR
//  Reset values: fetch_en=0, fetch_address=RESET_PC, PC=RESET_PC, instr_valid=0,
//   instruction=0, instr_pc=0, queue empty, in-flight clear, state=S_BOOT.
//  States:
//   S_BOOT  one cycle after rst release; no fetch; goes to S_RUN.
//   S_RUN   issues fetches under the credit rule.
//   S_HALT  entered when halt=1; no issue; in-flight data still lands.
//           Returns to S_RUN when halt=0.
//  Credit rule: fetch_en=1 only if occupancy + inflight < Q_DEPTH, where inflight is 0 or 1.
//   On issue: fetch_address=PC, then PC<=PC+PC_STEP (mod 2^ADDR_W; wraps to 0).
//  Landing: the cycle after issue, {fetch_out, issued addr} is pushed, unless the flight
//   is marked stale.
//  Pop: happens when instr_valid & instr_ready. Push and pop in the same cycle are legal
//   at any occupancy, including full, and leave occupancy unchanged.
//  Latency: first instr_valid occurs 3 cycles after rst release, with instr_pc=RESET_PC.
//   With instr_ready=1 throughout, throughput is 1 instruction/cycle.
//  Redirect (branch_en=1):
//   - same cycle: queue flushed; any fetch in flight or issued this cycle marked stale;
//     PC<=branch_target.
//   - next cycle: instr_valid=0; fetch_address=branch_target if credit and state allow.
//   - A pop coincident with branch_en completes (consumer owns it).
//  Priority: rst > branch_en > halt > normal issue.
//   branch_en while halted updates PC and flushes; state stays S_HALT.
//  Reset mid-operation: asynchronous return to reset values; stale data landing after
//   release is ignored because in-flight is cleared.
// CONFIGURATION
//  IFU_PERF_CNT_EN defined: adds outputs perf_fetched [31:0] (pushes accepted),
//   perf_flushes [15:0] (branch_en pulses) and perf_stall [31:0] (cycles with
//   instr_valid & !instr_ready). All reset to 0 and saturate at all-ones.
//  Undefined: those ports and counters are absent; the rest is unchanged.
// STRUCTURE
//  Package ifu_pkg:
//   - state enum {S_BOOT, S_RUN, S_HALT};
//   - localparam helper for the occupancy width, $clog2(Q_DEPTH)+1;
//   - PERF counter widths.
//  Sub-module ifu_queue: synchronous FIFO of {ADDR_W+INSTR_W} bits.
//   - ports: push, pop, flush, full, empty, count.
//   - flush takes priority over push within ifu_queue.
//  Top: FSM, PC register, in-flight/stale flags, credit logic.
// TESTING
//  1 rst pulse, then instr_ready=1: fetch_address 0,1,2,3...; first instr_valid at
//    cycle 3, instr_pc=0x0000, then increments by 1 each cycle.
//  2 instr_ready=0 from reset: exactly 4 fetches are issued, then fetch_en=0 and
//    occupancy=4. Raising instr_ready for 1 cycle causes exactly 1 new fetch.
//  3 branch_en with branch_target=0x0040 while the queue holds 3 entries and 1 is in
//    flight: next cycle instr_valid=0; fetch_address=0x0040; next valid instr_pc=0x0040;
//    no stale PC emerges.
//  4 PC=0xFFFF: fetches 0xFFFF then 0x0000. Separately, a full queue with push+pop in
//    the same cycle keeps occupancy at 4 with FIFO order intact.
//  5 halt=1 for 5 cycles: no fetch_en; the in-flight word still lands; halt=0 resumes
//    at the correct PC.
//  6 rst asserted mid-stream between clock edges: outputs reset immediately. After
//    release, the sequence restarts at RESET_PC; perf counters read 0 when
//    IFU_PERF_CNT_EN is defined.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared state encoding, occupancy width helper and perf counter widths for the fetch unit.
package ifu_pkg;
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;
  localparam int PERF_FETCH_W = 32;
  localparam int PERF_FLUSH_W = 16;
  localparam int PERF_STALL_W = 32;
  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/ifu_queue.sv
// ifu_queue: power-of-two synchronous FIFO for prefetched {pc, instruction} pairs; flush beats push.
module ifu_queue
  import ifu_pkg::*;
#(
  parameter int W     = 48,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic                      i_flush,
  input  logic [W-1:0]              i_din,
  output logic [W-1:0]              o_dout,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [occ_w(DEPTH)-1:0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = occ_w(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_wr, w_rd;
  assign o_full  = int'(r_cnt) == DEPTH;
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rd];
  assign w_rd    = i_pop && !o_empty;
  // a pop frees the slot the push lands in, so push+pop is legal even when full
  assign w_wr    = i_push && (!o_full || w_rd);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      r_wr  <= r_wr + AW'(w_wr);
      r_rd  <= r_rd + AW'(w_rd);
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
    end
  end
  always_ff @(posedge clk) begin
    if (w_wr && !i_flush) r_mem[r_wr] <= i_din;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, credit-limited RAM fetch and prefetch queue with branch flush and halt.
// Defining IFU_PERF_CNT_EN adds saturating perf_fetched/perf_flushes/perf_stall outputs.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int INSTR_W  = 32,
  parameter int Q_DEPTH  = 4,
  parameter int PC_STEP  = 1,
  parameter int RESET_PC = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    fetch_en,
  output logic [ADDR_W-1:0]       fetch_address,
  input  logic [INSTR_W-1:0]      fetch_out,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [INSTR_W-1:0]      instruction,
  output logic [ADDR_W-1:0]       instr_pc,
  input  logic                    branch_en,
  input  logic [ADDR_W-1:0]       branch_target,
  input  logic                    halt,
  output logic [ADDR_W-1:0]       PC
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [PERF_FETCH_W-1:0] perf_fetched,
  output logic [PERF_FLUSH_W-1:0] perf_flushes,
  output logic [PERF_STALL_W-1:0] perf_stall
`endif
);
  localparam int OCC_W = occ_w(Q_DEPTH);
  state_t                    r_state, w_next;
  logic [ADDR_W-1:0]         r_pc, r_fl_pc;
  logic                      r_inflight, r_stale;
  logic                      w_push, w_pop, w_full, w_empty, w_credit;
  logic [OCC_W-1:0]          w_count;
  logic [ADDR_W+INSTR_W-1:0] w_head;
  always_comb begin
    w_credit = !w_full && (int'(w_count) + int'(r_inflight) < Q_DEPTH);
    fetch_en = (r_state == S_RUN) && !halt && w_credit;
    w_next   = (r_state == S_BOOT) ? S_RUN : (halt ? S_HALT : S_RUN);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_BOOT;
      r_pc       <= ADDR_W'(RESET_PC);
      r_fl_pc    <= '0;
      r_inflight <= 1'b0;
      r_stale    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_pc       <= branch_en ? branch_target : (fetch_en ? r_pc + ADDR_W'(PC_STEP) : r_pc);
      r_fl_pc    <= fetch_en ? r_pc : r_fl_pc;
      r_inflight <= fetch_en;
      // a fetch issued alongside a redirect belongs to the old path and must not land
      r_stale    <= fetch_en && branch_en;
    end
  end
  assign fetch_address = r_pc;
  assign PC            = r_pc;
  assign w_push        = r_inflight && !r_stale;
  assign w_pop         = instr_valid && instr_ready;
  assign instr_valid   = !w_empty;
  assign instruction   = instr_valid ? w_head[INSTR_W-1:0] : '0;
  assign instr_pc      = instr_valid ? w_head[ADDR_W+INSTR_W-1 -: ADDR_W] : '0;
  ifu_queue #(.W(ADDR_W + INSTR_W), .DEPTH(Q_DEPTH)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (branch_en),
    .i_din   ({r_fl_pc, fetch_out}),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
      perf_stall   <= '0;
    end else begin
      perf_fetched <= perf_fetched + PERF_FETCH_W'(w_push && !branch_en && !(&perf_fetched));
      perf_flushes <= perf_flushes + PERF_FLUSH_W'(branch_en && !(&perf_flushes));
      perf_stall   <= perf_stall + PERF_STALL_W'(instr_valid && !instr_ready && !(&perf_stall));
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vector table for the fetch unit plus a hand sequence on the queue.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en, instr_valid, instr_ready = 1'b0, branch_en = 1'b0, halt = 1'b0;
  logic [15:0] fetch_address, instr_pc, branch_target = '0, PC;
  logic [31:0] fetch_out, instruction;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall;
  logic [15:0] perf_flushes;
`endif
  logic        q_push = 1'b0, q_pop = 1'b0, q_flush = 1'b0, q_full, q_empty;
  logic [7:0]  q_din = '0, q_dout;
  logic [2:0]  q_count;
  int          total = 0, bad = 0;

  typedef struct {
    logic rst, rdy, hlt, br;
    logic [15:0] tgt;
    logic fen;
    logic [15:0] pc;
    logic vld;
    logic [15:0] ipc;
  } vec_t;
  vec_t tv[$];

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .fetch_address(fetch_address),
    .fetch_out(fetch_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc), .branch_en(branch_en),
    .branch_target(branch_target), .halt(halt), .PC(PC)
`ifdef IFU_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_flushes(perf_flushes), .perf_stall(perf_stall)
`endif
  );

  ifu_queue #(.W(8), .DEPTH(4)) uq (
    .clk(clk), .rst(rst), .i_push(q_push), .i_pop(q_pop), .i_flush(q_flush),
    .i_din(q_din), .o_dout(q_dout), .o_full(q_full), .o_empty(q_empty), .o_count(q_count)
  );

  function automatic logic [31:0] ram(input logic [15:0] a);
    return {a ^ 16'hC3A5, a};
  endfunction

  always @(posedge clk) fetch_out <= fetch_en ? ram(fetch_address) : 32'hDEAD_BEEF;

  function automatic vec_t mk(input logic r, rd, h, b, input logic [15:0] t,
                              input logic f, input logic [15:0] p, input logic v, input logic [15:0] ip);
    vec_t x;
    x.rst = r; x.rdy = rd; x.hlt = h; x.br = b; x.tgt = t;
    x.fen = f; x.pc = p; x.vld = v; x.ipc = ip;
    return x;
  endfunction

  task automatic chk(input string n, input int row, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h want %h", n, row, act, exp);
    end
  endtask

  initial begin
    // rst rdy hlt br tgt | fen pc vld ipc
    tv.push_back(mk(1,1,0,0,16'h0,    0,16'h0000,0,16'h0));
    tv.push_back(mk(0,1,0,0,16'h0,    0,16'h0000,0,16'h0));
    tv.push_back(mk(0,1,0,0,16'h0,    1,16'h0000,0,16'h0));
    tv.push_back(mk(0,1,0,0,16'h0,    1,16'h0001,0,16'h0));
    tv.push_back(mk(0,1,0,0,16'h0,    1,16'h0002,1,16'h0000));
    tv.push_back(mk(0,1,0,0,16'h0,    1,16'h0003,1,16'h0001));
    tv.push_back(mk(0,1,0,0,16'h0,    1,16'h0004,1,16'h0002));
    tv.push_back(mk(1,0,0,0,16'h0,    0,16'h0000,0,16'h0));
    tv.push_back(mk(0,0,0,0,16'h0,    0,16'h0000,0,16'h0));
    tv.push_back(mk(0,0,0,0,16'h0,    1,16'h0000,0,16'h0));
    tv.push_back(mk(0,0,0,0,16'h0,    1,16'h0001,0,16'h0));
    tv.push_back(mk(0,0,0,0,16'h0,    1,16'h0002,1,16'h0000));
    tv.push_back(mk(0,0,0,0,16'h0,    1,16'h0003,1,16'h0000));
    tv.push_back(mk(0,0,0,0,16'h0,    0,16'h0004,1,16'h0000));
    tv.push_back(mk(0,0,0,0,16'h0,    0,16'h0004,1,16'h0000));
    tv.push_back(mk(0,0,0,0,16'h0,    0,16'h0004,1,16'h0000));
    tv.push_back(mk(0,1,0,0,16'h0,    0,16'h0004,1,16'h0000));
    tv.push_back(mk(0,0,0,0,16'h0,    1,16'h0004,1,16'h0001));
    tv.push_back(mk(0,0,0,0,16'h0,    0,16'h0005,1,16'h0001));
    tv.push_back(mk(0,0,0,0,16'h0,    0,16'h0005,1,16'h0001));
    tv.push_back(mk(0,1,0,0,16'h0,    0,16'h0005,1,16'h0001));
    tv.push_back(mk(0,0,0,0,16'h0,    1,16'h0005,1,16'h0002));
    tv.push_back(mk(0,0,0,1,16'h0040, 0,16'h0006,1,16'h0002));
    tv.push_back(mk(0,1,0,0,16'h0,    1,16'h0040,0,16'h0));
    tv.push_back(mk(0,1,0,0,16'h0,    1,16'h0041,0,16'h0));
    tv.push_back(mk(0,1,0,0,16'h0,    1,16'h0042,1,16'h0040));
    tv.push_back(mk(0,1,0,0,16'h0,    1,16'h0043,1,16'h0041));
    tv.push_back(mk(0,1,0,1,16'hFFFF, 1,16'h0044,1,16'h0042));
    tv.push_back(mk(0,1,0,0,16'h0,    1,16'hFFFF,0,16'h0));
    tv.push_back(mk(0,1,0,0,16'h0,    1,16'h0000,0,16'h0));
    tv.push_back(mk(0,1,0,0,16'h0,    1,16'h0001,1,16'hFFFF));
    tv.push_back(mk(0,1,0,0,16'h0,    1,16'h0002,1,16'h0000));
    for (int k = 0; k < 5; k++) tv.push_back(mk(0,0,1,0,16'h0, 0,16'h0003,1,16'h0001));
    tv.push_back(mk(0,1,0,0,16'h0,    0,16'h0003,1,16'h0001));
    tv.push_back(mk(0,1,0,0,16'h0,    1,16'h0003,1,16'h0002));
    tv.push_back(mk(0,1,0,0,16'h0,    1,16'h0004,0,16'h0));
    tv.push_back(mk(0,1,0,0,16'h0,    1,16'h0005,1,16'h0003));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst = tv[i].rst; instr_ready = tv[i].rdy; halt = tv[i].hlt;
      branch_en = tv[i].br; branch_target = tv[i].tgt;
      #1;
      chk("fetch_en", i, 64'(fetch_en), 64'(tv[i].fen));
      chk("pc", i, 64'(PC), 64'(tv[i].pc));
      if (tv[i].fen) chk("fetch_address", i, 64'(fetch_address), 64'(tv[i].pc));
      chk("instr_valid", i, 64'(instr_valid), 64'(tv[i].vld));
      if (tv[i].vld) begin
        chk("instr_pc", i, 64'(instr_pc), 64'(tv[i].ipc));
        chk("instruction", i, 64'(instruction), 64'(ram(tv[i].ipc)));
      end
      if (tv[i].rst) begin
        chk("rst_instruction", i, 64'(instruction), 64'h0);
        chk("rst_instr_pc", i, 64'(instr_pc), 64'h0);
        chk("rst_fetch_address", i, 64'(fetch_address), 64'h0);
`ifdef IFU_PERF_CNT_EN
        chk("rst_perf", i, {perf_fetched, perf_stall} | 64'(perf_flushes), 64'h0);
`endif
      end
    end
    @(negedge clk);
    branch_en = 1'b0; halt = 1'b0; instr_ready = 1'b0;

    for (int k = 0; k < 4; k++) begin
      q_push = 1'b1; q_din = 8'(8'h10 + k);
      @(negedge clk);
    end
    q_push = 1'b0;
    #1;
    chk("q_fill_count", 0, 64'(q_count), 64'd4);
    chk("q_full", 0, 64'(q_full), 64'd1);
    chk("q_head", 0, 64'(q_dout), 64'h10);
    @(negedge clk);
    q_push = 1'b1; q_pop = 1'b1; q_din = 8'h14;
    @(negedge clk);
    q_push = 1'b0; q_pop = 1'b0;
    #1;
    chk("q_pushpop_count", 1, 64'(q_count), 64'd4);
    chk("q_pushpop_full", 1, 64'(q_full), 64'd1);
    for (int k = 0; k < 4; k++) begin
      chk("q_order", 2 + k, 64'(q_dout), 64'(8'h11 + k));
      @(negedge clk);
      q_pop = 1'b1;
      @(negedge clk);
      q_pop = 1'b0;
      #1;
    end
    chk("q_drained", 6, 64'(q_empty), 64'd1);
    q_push = 1'b1; q_flush = 1'b1; q_din = 8'h77;
    @(negedge clk);
    q_push = 1'b0; q_flush = 1'b0;
    #1;
    chk("q_flush_wins", 7, 64'(q_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
